// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: frame geometry, baud tick limits and receiver FSM states.
// Also consumed by uart_transmitter so both ends agree on rates and framing.
package uart_receiver_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int FRAME_BITS = 11;
    localparam int BAUD_CNT_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Tick period in clk cycles for each rate code (100 MHz / (16 x baud)).
    function automatic logic [BAUD_CNT_W-1:0] baud_limit(input logic [2:0] sel);
        logic [BAUD_CNT_W-1:0] lim;
        case (sel)
            3'd0:    lim = 15'd20833;
            3'd1:    lim = 15'd5208;
            3'd2:    lim = 15'd1302;
            3'd3:    lim = 15'd651;
            3'd4:    lim = 15'd326;
            3'd5:    lim = 15'd163;
            3'd6:    lim = 15'd109;
            default: lim = 15'd54;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// Oversample tick generator: one-clk sample_ENABLE pulse every baud_limit(baud_select) clks.
// clear restarts the period so the first tick lands a fixed distance after a start edge.
module baud_controller
    import uart_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       clear,
    output logic       sample_ENABLE
);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;
    logic [BAUD_CNT_W-1:0] limit;

    always_comb begin
        limit         = baud_limit(baud_select);
        // >= rather than == so a counter left past a smaller limit still wraps promptly
        sample_ENABLE = (cnt_q >= limit - BAUD_CNT_W'(1));
        cnt_d         = cnt_q + BAUD_CNT_W'(1);
        if (clear || sample_ENABLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver: 16x oversampled, mid-bit sampling, byte + valid pulse or error flags.
// Results appear one clk after the stop-bit sample; there is no backpressure on the output.
module uart_receiver #(
    parameter int OVERSAMPLE  = uart_receiver_pkg::OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);
    import uart_receiver_pkg::*;

    localparam int            TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] END_TICK = TW'(OVERSAMPLE - 1);

    rx_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   stop_q, stop_d;
    logic                   finish_q, finish_d;
    logic [2:0]             baud_sel_q, baud_sel_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_perror_q, rx_perror_d;
    logic                   rx_ferror_q, rx_ferror_d;

    logic rx_s;
    logic start_edge;
    logic sample_en;
    logic baud_clr;

    baud_controller u_baud (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (baud_sel_q),
        .clear         (baud_clr),
        .sample_ENABLE (sample_en)
    );

    always_comb begin
        rx_s        = sync_q[SYNC_STAGES-1];
        // Needs a sampled 1 before the 0, so a stuck-low line never re-triggers
        start_edge  = rx_prev_q & ~rx_s;
        sync_d      = SYNC_STAGES'({sync_q, RxD});
        rx_prev_d   = rx_s;
        state_d     = state_q;
        tick_cnt_d  = sample_en ? tick_cnt_q + TW'(1) : tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        stop_d      = stop_q;
        finish_d    = 1'b0;
        baud_sel_d  = baud_sel_q;
        baud_clr    = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_perror_d = rx_perror_q;
        rx_ferror_d = rx_ferror_q;

        case (state_q)
            ST_IDLE: begin
                if (Rx_EN && start_edge) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    baud_clr   = 1'b1;
                    baud_sel_d = baud_select;
                end
            end
            ST_START: begin
                if (sample_en && tick_cnt_q == MID_TICK) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Start confirmed: this is where stale error flags are dropped
                        state_d     = ST_DATA;
                        tick_cnt_d  = '0;
                        bit_cnt_d   = '0;
                        rx_perror_d = 1'b0;
                        rx_ferror_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (sample_en && tick_cnt_q == END_TICK) begin
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_en && tick_cnt_q == END_TICK) begin
                    perr_d  = (^shift_q) ^ rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_en && tick_cnt_q == END_TICK) begin
                    stop_d   = rx_s;
                    finish_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable beats a stop sample in the same clk, so the frame is dropped entirely
        if (!Rx_EN) begin
            state_d  = ST_IDLE;
            finish_d = 1'b0;
        end

        if (finish_q) begin
            rx_data_d   = shift_q;
            rx_perror_d = perr_q;
            rx_ferror_d = ~stop_q;
            rx_valid_d  = ~perr_q & stop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sync_q      <= '1;
            rx_prev_q   <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            stop_q      <= 1'b0;
            finish_q    <= 1'b0;
            baud_sel_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perror_q <= 1'b0;
            rx_ferror_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rx_prev_q   <= rx_prev_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            stop_q      <= stop_d;
            finish_q    <= finish_d;
            baud_sel_q  <= baud_sel_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_perror_q <= rx_perror_d;
            rx_ferror_q <= rx_ferror_d;
        end
    end

    assign Rx_DATA   = rx_data_q;
    assign Rx_VALID  = rx_valid_q;
    assign Rx_PERROR = rx_perror_q;
    assign Rx_FERROR = rx_ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised frame stimulus (bytes and +/-3% bit-period skew) checked against a frame-level model.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    uart_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    always #5 clk = ~clk;

    int lim_tab [8] = '{20833, 5208, 1302, 651, 326, 163, 109, 54};

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int long_cnt = 0;
    int last_valid_cyc = 0;
    logic valid_prev = 1'b0;

    // Reference state of the receiver outputs at frame granularity
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    int         exp_valid;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        valid_prev <= Rx_VALID;
        if (Rx_VALID) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (Rx_VALID && valid_prev) long_cnt <= long_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                               input logic stop_val);
        logic par;
        par = 1'(($countones(b) + (bad_par ? 1 : 0)) % 2);
        return {stop_val, par, b, 1'b0};
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic stop_val);
        exp_data = b;
        exp_perr = bad_par;
        exp_ferr = !stop_val;
        if (!bad_par && stop_val) exp_valid++;
    endtask

    function automatic int skewed(input int nominal);
        return nominal * (970 + int'($urandom_range(0, 60))) / 1000;
    endfunction

    int t0;

    task automatic drive_range(input logic [10:0] fr, input int lo, input int hi, input int bclk);
        for (int i = lo; i <= hi; i++) begin
            if (i == 0) t0 = cyc;
            RxD = fr[i];
            repeat (bclk) @(negedge clk);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"}, 32'(Rx_DATA), 32'(exp_data));
        check({tag, "_perr"}, 32'(Rx_PERROR), 32'(exp_perr));
        check({tag, "_ferr"}, 32'(Rx_FERROR), 32'(exp_ferr));
        check({tag, "_valid_cnt"}, valid_cnt, exp_valid);
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  b;
        int          bclk;
        int          nom;
        int          dt;

        exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0; exp_valid = 0;
        reset = 1'b1; Rx_EN = 1'b0; RxD = 1'b1; baud_select = 3'b000;
        repeat (10) @(negedge clk);
        check("rst_valid", 32'(Rx_VALID), 0);
        check_outputs("rst");
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        Rx_EN = 1'b1;
        baud_select = 3'b111;
        repeat (20) @(negedge clk);

        // 0xAA at 115200, with latency window on the valid pulse
        nom = 16 * lim_tab[7];
        bclk = skewed(nom);
        fr = make_frame(8'hAA, 1'b0, 1'b1);
        drive_range(fr, 0, 10, bclk);
        model_frame(8'hAA, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_outputs("aa");
        dt = last_valid_cyc - t0;
        check("aa_latency_window", 32'(dt >= 10 * nom && dt <= 11 * nom), 1);

        // 0x55 at 57600 with baud_select changed mid-frame
        baud_select = 3'b110;
        repeat (5) @(negedge clk);
        nom = 16 * lim_tab[6];
        bclk = skewed(nom);
        fr = make_frame(8'h55, 1'b0, 1'b1);
        drive_range(fr, 0, 4, bclk);
        baud_select = 3'b111;
        drive_range(fr, 5, 10, bclk);
        model_frame(8'h55, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_outputs("h55");
        dt = last_valid_cyc - t0;
        check("h55_latency_window", 32'(dt >= 10 * nom && dt <= 11 * nom), 1);

        // 0x0F with inverted parity
        nom = 16 * lim_tab[7];
        bclk = skewed(nom);
        fr = make_frame(8'h0F, 1'b1, 1'b1);
        drive_range(fr, 0, 10, bclk);
        model_frame(8'h0F, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check_outputs("perr");

        // Framing error then line held low: no re-trigger
        b = 8'($urandom);
        bclk = skewed(nom);
        fr = make_frame(b, 1'b0, 1'b0);
        drive_range(fr, 0, 10, bclk);
        repeat (2 * nom) @(negedge clk);
        model_frame(b, 1'b0, 1'b0);
        check_outputs("ferr");
        check("ferr_state", 32'(dut.state_q), 32'(ST_IDLE));
        RxD = 1'b1;
        repeat (20) @(negedge clk);

        // 200 ns glitch at 9600: START rejects it, flags untouched
        baud_select = 3'b011;
        repeat (5) @(negedge clk);
        RxD = 1'b0;
        repeat (20) @(negedge clk);
        RxD = 1'b1;
        repeat (8 * lim_tab[3] + 100) @(negedge clk);
        check_outputs("glitch");
        check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Good random frame clears the framing flag
        baud_select = 3'b111;
        repeat (5) @(negedge clk);
        b = 8'($urandom);
        bclk = skewed(nom);
        fr = make_frame(b, 1'b0, 1'b1);
        drive_range(fr, 0, 10, bclk);
        model_frame(b, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_outputs("good");

        // Rx_EN dropped halfway through DATA
        b = 8'($urandom);
        fr = make_frame(b, 1'b0, 1'b1);
        drive_range(fr, 0, 4, skewed(nom));
        Rx_EN = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        RxD = 1'b1;
        repeat (nom) @(negedge clk);
        Rx_EN = 1'b1;
        repeat (20) @(negedge clk);
        check_outputs("abort");

        // Reset mid-frame returns everything to reset values
        b = 8'($urandom);
        fr = make_frame(b, 1'b0, 1'b1);
        drive_range(fr, 0, 5, skewed(nom));
        RxD = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0;
        check_outputs("midrst");
        check("midrst_valid", 32'(Rx_VALID), 0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (nom) @(negedge clk);
        check("midrst_valid_cnt_after", valid_cnt, exp_valid);

        check("valid_single_clk", long_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
